// File: rtl/bsg_fifo_rolly_replay_ctrl.sv
// Replay sequencer for a rollback-capable FIFO: hands reads out, commits on ack, rolls back on nack.
// Optional `define BSG_ROLLY_CTRL_TIMEOUT_EN adds an auto-roll after timeout_p cycles without an ack.
module bsg_fifo_rolly_replay_ctrl #(
    parameter int unsigned els_p       = 8,
    parameter int unsigned max_retry_p = 3,
    parameter int unsigned timeout_p   = 64
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         fifo_v_i,
    output logic                         fifo_yumi_o,
    output logic                         fifo_deq_v_o,
    output logic                         fifo_roll_v_o,
    output logic                         fifo_clr_v_o,
    output logic                         v_o,
    input  logic                         yumi_i,
    input  logic                         ack_v_i,
    input  logic                         nack_v_i,
    input  logic                         flush_i,
    output logic [$clog2(els_p+1)-1:0]   inflight_o,
    output logic                         error_o
);

    localparam int unsigned inf_w_c   = $clog2(els_p + 1);
    localparam int unsigned retry_w_c = (max_retry_p < 1) ? 1 : $clog2(max_retry_p + 1);

    localparam logic [inf_w_c-1:0]   inf_one_c   = inf_w_c'(1);
    localparam logic [retry_w_c-1:0] retry_one_c = retry_w_c'(1);
    localparam logic [retry_w_c-1:0] max_retry_c = retry_w_c'(max_retry_p);

    if (timeout_p < 2 || els_p < 1) begin : g_param_check
        $error("bsg_fifo_rolly_replay_ctrl: els_p must be >= 1 and timeout_p >= 2");
    end

    typedef enum logic [1:0] {RUN, ROLL, ERROR} state_e;

    state_e                 state;
    logic [inf_w_c-1:0]     inflight;
    logic [retry_w_c-1:0]   retry;
    logic                   error_r;

    logic                   active;
    logic                   has_inflight;
    logic                   timeout_fire;
    logic                   go_replay;
    logic                   go_roll;
    logic                   go_error;
    logic [retry_w_c-1:0]   retry_eff;

    always_comb begin
        active        = !reset_i;
        has_inflight  = (inflight != '0);
        v_o           = active && (state == RUN) && fifo_v_i && !flush_i;
        fifo_yumi_o   = v_o && yumi_i;
        fifo_deq_v_o  = active && ack_v_i && has_inflight;
        fifo_roll_v_o = active && (state == ROLL);
        fifo_clr_v_o  = active && flush_i;
        // a same-cycle ack clears retry before the replay request is judged
        retry_eff     = fifo_deq_v_o ? '0 : retry;
        go_replay     = active && (state == RUN) && has_inflight && (nack_v_i || timeout_fire);
        go_roll       = go_replay && (retry_eff < max_retry_c);
        go_error      = go_replay && !(retry_eff < max_retry_c);
    end

    assign inflight_o = inflight;
    assign error_o    = error_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= RUN;
            inflight <= '0;
            retry    <= '0;
            error_r  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (go_roll) begin
                        state <= ROLL;
                        retry <= retry_eff + retry_one_c;
                    end else if (go_error) begin
                        state   <= ERROR;
                        error_r <= 1'b1;
                        retry   <= retry_eff;
                    end else begin
                        retry <= retry_eff;
                    end
                end
                ROLL: begin
                    state <= RUN;
                    retry <= retry_eff;
                end
                ERROR: begin
                    retry <= retry_eff;
                end
                default: begin
                    state <= RUN;
                end
            endcase

            if (state == ROLL) begin
                inflight <= '0;
            end else if (fifo_yumi_o && !fifo_deq_v_o) begin
                inflight <= inflight + inf_one_c;
            end else if (fifo_deq_v_o && !fifo_yumi_o) begin
                inflight <= inflight - inf_one_c;
            end
        end
    end

`ifdef BSG_ROLLY_CTRL_TIMEOUT_EN
    localparam int unsigned          timer_w_c    = $clog2(timeout_p);
    localparam logic [timer_w_c-1:0] timer_last_c = timer_w_c'(timeout_p - 1);
    localparam logic [timer_w_c-1:0] timer_one_c  = timer_w_c'(1);

    logic [timer_w_c-1:0] timer;

    assign timeout_fire = (state == RUN) && has_inflight && !ack_v_i && (timer == timer_last_c);

    always_ff @(posedge clk_i) begin
        if (reset_i || (state != RUN) || !has_inflight || fifo_deq_v_o || go_replay) begin
            timer <= '0;
        end else begin
            timer <= timer + timer_one_c;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_fifo_rolly_replay_ctrl.sv
// Directed bench for bsg_fifo_rolly_replay_ctrl: streaming, nack replay, retry exhaustion, flush, timeout.
module tb_bsg_fifo_rolly_replay_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_v, yumi, ack, nack, flush;
    logic       fyumi, deq, roll, clr, v, err;
    logic [3:0] inflight;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // expected-output bit positions: {v, yumi, deq, roll, clr, err}
    localparam logic [5:0] BV = 6'b100000;
    localparam logic [5:0] BY = 6'b010000;
    localparam logic [5:0] BD = 6'b001000;
    localparam logic [5:0] BR = 6'b000100;
    localparam logic [5:0] BC = 6'b000010;
    localparam logic [5:0] BE = 6'b000001;

    always #5 clk = ~clk;

    bsg_fifo_rolly_replay_ctrl #(
        .els_p      (8),
        .max_retry_p(3),
        .timeout_p  (8)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .fifo_v_i     (fifo_v),
        .fifo_yumi_o  (fyumi),
        .fifo_deq_v_o (deq),
        .fifo_roll_v_o(roll),
        .fifo_clr_v_o (clr),
        .v_o          (v),
        .yumi_i       (yumi),
        .ack_v_i      (ack),
        .nack_v_i     (nack),
        .flush_i      (flush),
        .inflight_o   (inflight),
        .error_o      (err)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic y, input logic a, input logic n, input logic f);
        fifo_v = fv;
        yumi   = y;
        ack    = a;
        nack   = n;
        flush  = f;
        #2;
    endtask

    task automatic expect_out(input string tag, input logic [5:0] bits, input int unsigned inf);
        check_eq(tag, {26'd0, v, fyumi, deq, roll, clr, err}, {26'd0, bits});
        check_eq({tag, ".inf"}, {28'd0, inflight}, inf);
    endtask

    task automatic cyc(input logic fv, input logic y, input logic a, input logic n, input logic f,
                       input string tag, input logic [5:0] bits, input int unsigned inf);
        drive(fv, y, a, n, f);
        expect_out(tag, bits, inf);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1, 1, 1, 1, 1);
        tick();
        expect_out("rst", 6'b0, 0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        do_reset();

        // streaming: read one per cycle, ack on the following cycle
        cyc(1, 1, 0, 0, 0, "s0", BV | BY, 0);
        cyc(1, 1, 1, 0, 0, "s1", BV | BY | BD, 1);
        cyc(1, 1, 1, 0, 0, "s2", BV | BY | BD, 1);
        cyc(1, 1, 1, 0, 0, "s3", BV | BY | BD, 1);
        cyc(1, 0, 1, 0, 0, "s4", BV | BD, 1);
        cyc(0, 0, 0, 0, 0, "s5", 6'b0, 0);
        // nack / ack with nothing in flight are ignored; yumi with v_o low ignored
        cyc(0, 1, 0, 1, 0, "nack0", 6'b0, 0);
        cyc(0, 0, 0, 0, 0, "nack0_noroll", 6'b0, 0);
        cyc(1, 0, 1, 0, 0, "ack0", BV, 0);

        // read 3, nack, roll, replay 3, drain
        cyc(1, 1, 0, 0, 0, "r0", BV | BY, 0);
        cyc(1, 1, 0, 0, 0, "r1", BV | BY, 1);
        cyc(1, 1, 0, 0, 0, "r2", BV | BY, 2);
        cyc(1, 0, 0, 1, 0, "nk", BV, 3);
        cyc(1, 1, 0, 1, 0, "roll", BR, 3);
        cyc(1, 1, 0, 0, 0, "rp0", BV | BY, 0);
        cyc(1, 1, 0, 0, 0, "rp1", BV | BY, 1);
        cyc(1, 1, 0, 0, 0, "rp2", BV | BY, 2);
        cyc(1, 0, 1, 0, 0, "dr0", BV | BD, 3);
        cyc(1, 0, 1, 0, 0, "dr1", BV | BD, 2);
        cyc(1, 0, 1, 0, 0, "dr2", BV | BD, 1);
        cyc(0, 0, 0, 0, 0, "dr3", 6'b0, 0);

        // same-cycle ack+nack leaves retry=1, so three more nacks reach ERROR
        cyc(1, 1, 0, 0, 0, "an_r0", BV | BY, 0);
        cyc(1, 1, 0, 0, 0, "an_r1", BV | BY, 1);
        cyc(1, 0, 1, 1, 0, "an", BV | BD, 2);
        cyc(1, 0, 0, 0, 0, "an_roll", BR, 1);
        cyc(1, 1, 0, 0, 0, "an_rp", BV | BY, 0);
        cyc(1, 0, 0, 1, 0, "rt2_nk", BV, 1);
        cyc(1, 0, 0, 0, 0, "rt2_roll", BR, 1);
        cyc(1, 1, 0, 0, 0, "rt3_rd", BV | BY, 0);
        cyc(1, 0, 0, 1, 0, "rt3_nk", BV, 1);
        cyc(1, 0, 0, 0, 0, "rt3_roll", BR, 1);
        cyc(1, 1, 0, 0, 0, "rt4_rd", BV | BY, 0);
        cyc(1, 0, 0, 1, 0, "rt4_nk", BV, 1);
        cyc(1, 1, 0, 0, 0, "rt_err", BE, 1);
        do_reset();

        // four nacks without ack: three rolls then ERROR
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 0, "x_rd", BV | BY, 0);
            cyc(1, 0, 0, 1, 0, "x_nk", BV, 1);
            cyc(1, 0, 0, 0, 0, "x_roll", BR, 1);
        end
        cyc(1, 1, 0, 0, 0, "x_rd4", BV | BY, 0);
        cyc(1, 0, 0, 1, 0, "x_nk4", BV, 1);
        cyc(1, 1, 0, 1, 0, "e_hold", BE, 1);
        cyc(1, 0, 1, 0, 0, "e_ack", BE | BD, 1);
        cyc(1, 0, 0, 0, 1, "e_flush", BE | BC, 0);
        cyc(0, 0, 1, 0, 0, "e_ack0", BE, 0);
        do_reset();
        cyc(1, 0, 0, 0, 0, "post_rst", BV, 0);

        // flush leaves in-flight entries alone
        cyc(1, 1, 0, 0, 0, "f_r0", BV | BY, 0);
        cyc(1, 1, 0, 0, 0, "f_r1", BV | BY, 1);
        cyc(1, 1, 0, 0, 1, "fl", BC, 2);
        cyc(1, 0, 1, 0, 0, "fa0", BV | BD, 2);
        cyc(1, 0, 1, 0, 0, "fa1", BV | BD, 1);
        cyc(0, 0, 0, 0, 0, "fa2", 6'b0, 0);

        // reset landing on a ROLL cycle suppresses the roll
        cyc(1, 1, 0, 0, 0, "rr_rd", BV | BY, 0);
        cyc(1, 0, 0, 1, 0, "rr_nk", BV, 1);
        rst = 1'b1;
        cyc(1, 0, 0, 0, 0, "rr_rst", 6'b0, 1);
        rst = 1'b0;
        cyc(1, 0, 0, 0, 0, "rr_run", BV, 0);

        // timeout: one read then silence
        cyc(1, 1, 0, 0, 0, "to_rd", BV | BY, 0);
`ifdef BSG_ROLLY_CTRL_TIMEOUT_EN
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0, 0, 0, "to", (k == 9) ? BR : 6'b0, (k <= 9) ? 1 : 0);
        end
`else
        for (int k = 1; k <= 100; k++) begin
            cyc(0, 0, 0, 0, 0, "to", 6'b0, 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
